// File: rtl/lib_arbiter_pkg.sv
// Shared definitions for the event readout path.
// Holds the event word width, the type-nibble encodings used to tell
// timebase words from CD words, the output-buffer FSM states, and small
// word-classification helpers used by event_out_buffer.
package lib_arbiter_pkg;

  localparam int unsigned EVT_W = 32;

  localparam logic [3:0] EVT_TYPE_TH     = 4'b1000;
  localparam logic [3:0] EVT_TYPE_CD_ON  = 4'b0001;
  localparam logic [3:0] EVT_TYPE_CD_OFF = 4'b0000;

  typedef enum logic {OB_NORMAL, OB_PEND_TH} obuf_state_t;

  function automatic logic is_time_high(input logic [EVT_W-1:0] word);
    return word[EVT_W-1 -: 4] == EVT_TYPE_TH;
  endfunction

  // CD_ON and CD_OFF share the 3'b000 prefix; the low type bit is polarity.
  function automatic logic is_cd(input logic [EVT_W-1:0] word);
    return word[EVT_W-1 -: 3] == EVT_TYPE_CD_OFF[3:1];
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Single-clock FIFO with a registered head word.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   push_i, data_i  write request and word (ignored when full)
//   pop_i           advance head (ignored when empty)
//   data_o          registered head word, held while not popped
//   full_o/empty_o  occupancy flags from the registered level
//   level_o         current occupancy, 0..DEPTH
module evt_sync_fifo
  import lib_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = EVT_W
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // The head register is loaded with whatever will be at the head after this
  // edge. When the FIFO is (or becomes) otherwise empty, the incoming word
  // bypasses memory so it appears on the very next cycle.
  always_comb begin
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok  ? rd_q + AW'(1) : rd_q;
    level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    head_d  = head_q;
    if (push_ok && (level_q == {{AW{1'b0}}, pop_ok})) begin
      head_d = data_i;
    end else if (level_d != '0) begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  assign data_o  = head_q;
  assign level_o = level_q;

endmodule

// File: rtl/event_out_buffer.sv
// Output buffer between event_encoder and the readout link.
// The encoder cannot be stalled, so words arriving while the FIFO is full
// are dropped here. Dropped CD words are counted; a dropped TIME_HIGH word is
// kept aside and written back ahead of later traffic so the timebase is
// never lost.
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   valid_in_i, data_in_i     encoder word stream (no backpressure)
//   out_valid_o, out_data_o   link stream, out_ready_i accepts
//   level_o                   FIFO occupancy
//   overflow_o, drop_cnt_o    sticky drop flag and saturating CD drop count
//   clr_ovf_i                 clears overflow_o and drop_cnt_o
module event_out_buffer
  import lib_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIDTH = EVT_W
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid_in_i,
  input  logic [WIDTH-1:0]       data_in_i,
  input  logic                   out_ready_i,
  output logic                   out_valid_o,
  output logic [WIDTH-1:0]       out_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  input  logic                   clr_ovf_i
);

  obuf_state_t      state_q, state_d;
  logic [WIDTH-1:0] th_hold_q, th_hold_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             full, empty;
  logic             in_th, in_cd;
  logic             any_drop, cd_drop;

  assign in_th = is_time_high(data_in_i);
  assign in_cd = is_cd(data_in_i);

  evt_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (out_valid_o && out_ready_i),
    .data_o  (out_data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign out_valid_o = !empty;

  always_comb begin
    push      = 1'b0;
    push_data = data_in_i;
    state_d   = state_q;
    th_hold_d = th_hold_q;
    any_drop  = 1'b0;
    cd_drop   = 1'b0;
    unique case (state_q)
      OB_NORMAL: begin
        if (valid_in_i) begin
          if (!full) begin
            push = 1'b1;
          end else begin
            any_drop = 1'b1;
            if (in_th) begin
              th_hold_d = data_in_i;
              state_d   = OB_PEND_TH;
            end else begin
              cd_drop = in_cd;
            end
          end
        end
      end
      OB_PEND_TH: begin
        if (!full) begin
          // The first free slot goes to a timebase word: a fresh TIME_HIGH
          // supersedes the held one, otherwise the held one is written and
          // any same-cycle CD word is lost.
          push    = 1'b1;
          state_d = OB_NORMAL;
          if (valid_in_i && in_th) begin
            push_data = data_in_i;
          end else begin
            push_data = th_hold_q;
            if (valid_in_i) begin
              any_drop = 1'b1;
              cd_drop  = in_cd;
            end
          end
        end else if (valid_in_i) begin
          any_drop = 1'b1;
          if (in_th) begin
            th_hold_d = data_in_i;
          end else begin
            cd_drop = in_cd;
          end
        end
      end
      default: state_d = OB_NORMAL;
    endcase

    // Clear is applied first so a coincident drop still registers.
    ovf_d = clr_ovf_i ? 1'b0 : ovf_q;
    cnt_d = clr_ovf_i ? '0 : cnt_q;
    if (any_drop) begin
      ovf_d = 1'b1;
    end
    if (cd_drop && (cnt_d != '1)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= OB_NORMAL;
      th_hold_q <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      th_hold_q <= th_hold_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign overflow_o = ovf_q;
  assign drop_cnt_o = cnt_q;

endmodule
